dmi_initiator: RTL

DTM-side Debug Module Interface initiator: turns a captured JTAG `dmi` update (address, data, op) into a single DMI request to `dmi_main`. It then collects the response and returns it together with a sticky `op` status, as defined by the RISC-V Debug spec. It sits between the JTAG TAP/DTM register file and the DM's DMI request/response port. It drives the opposite end of the handshake that `dmi_main` responds to.

---
 rtl/dmi_pkg.sv | 22 ++
 rtl/dmi_initiator_timeout_cnt.sv | 36 +++
 rtl/dmi_initiator.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/dmi_pkg.sv
// Shared encodings for the DTM-side DMI initiator.
//   DMI_* : request op field carried on req_op / cmd_op
//   ST_*  : sticky status reported on res_op (matches rsp_op encoding)
//   dmi_state_e : initiator FSM states
package dmi_pkg;

  localparam logic [1:0] DMI_NOP   = 2'd0;
  localparam logic [1:0] DMI_READ  = 2'd1;
  localparam logic [1:0] DMI_WRITE = 2'd2;
  localparam logic [1:0] DMI_RSVD  = 2'd3;

  localparam logic [1:0] ST_OK     = 2'd0;
  localparam logic [1:0] ST_FAILED = 2'd2;
  localparam logic [1:0] ST_BUSY   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } dmi_state_e;

endpackage

// File: rtl/dmi_initiator_timeout_cnt.sv
// Saturating transfer-timeout counter.
//   i_clk, i_reset (async, active low)
//   i_clr     : restart count at zero (transfer accept / hard reset)
//   i_en      : count this cycle (transfer in flight)
//   o_expired : the edge closing this cycle brings the count to TIMEOUT
module dmi_timeout_cnt #(
  parameter int TIMEOUT = 1023
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int            CW     = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != C_MAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Flagged one count early so the FSM leaves on the very edge the count
  // reaches TIMEOUT, i.e. exactly TIMEOUT cycles after accept.
  assign o_expired = i_en && (r_cnt >= C_LAST);

endmodule

// File: rtl/dmi_initiator.sv
// DTM-side DMI initiator: converts a captured JTAG dmi update into one DMI
// request, collects the response and reports it with a sticky op status.
//   i_clk, i_reset (async, active low)
//   i_cmd_strobe/op/addr/data : command from DTM update-DR
//   i_dmireset                : clear sticky status
//   i_dmihardreset            : abort transfer and clear status
//   o_req_valid/i_req_ready, o_req_addr/data/op : DMI request channel
//   i_rsp_valid/o_rsp_ready, i_rsp_data/op      : DMI response channel
//   o_res_valid/data/op : completion pulse and held last result
//   o_busy              : transfer in flight
//
// state  | meaning
// S_IDLE | no transfer; strobes evaluated against sticky status
// S_REQ  | request presented, waiting for req_ready
// S_RSP  | request taken, waiting for rsp_valid or timeout
module dmi_initiator
  import dmi_pkg::*;
#(
  parameter int ABITS   = 7,
  parameter int WID     = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cmd_strobe,
  input  logic [1:0]       i_cmd_op,
  input  logic [ABITS-1:0] i_cmd_addr,
  input  logic [WID-1:0]   i_cmd_data,
  input  logic             i_dmireset,
  input  logic             i_dmihardreset,
  output logic             o_req_valid,
  input  logic             i_req_ready,
  output logic [ABITS-1:0] o_req_addr,
  output logic [WID-1:0]   o_req_data,
  output logic [1:0]       o_req_op,
  input  logic             i_rsp_valid,
  output logic             o_rsp_ready,
  input  logic [WID-1:0]   i_rsp_data,
  input  logic [1:0]       i_rsp_op,
  output logic             o_res_valid,
  output logic [WID-1:0]   o_res_data,
  output logic [1:0]       o_res_op,
  output logic             o_busy
);

  dmi_state_e       r_state;
  logic [1:0]       r_stat;
  logic [ABITS-1:0] r_req_addr;
  logic [WID-1:0]   r_req_data;
  logic [1:0]       r_req_op;
  logic             r_res_valid;
  logic [WID-1:0]   r_res_data;
  logic [1:0]       r_res_op;
  logic             r_rsp_ready;

  dmi_state_e       w_state_nxt;
  logic [1:0]       w_stat_base;
  logic [1:0]       w_stat_nxt;
  logic             w_load_cmd;
  logic             w_cnt_clr;
  logic             w_done;
  logic [WID-1:0]   w_res_data_nxt;
  logic             w_expired;

  dmi_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clr     (w_cnt_clr),
    .i_en      (r_state != S_IDLE),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    // dmireset clears first so a same-cycle strobe sees a clean status
    w_stat_base    = i_dmireset ? ST_OK : r_stat;
    w_stat_nxt     = w_stat_base;
    w_load_cmd     = 1'b0;
    w_cnt_clr      = 1'b0;
    w_done         = 1'b0;
    w_res_data_nxt = r_res_data;

    if (i_dmihardreset) begin
      w_state_nxt = S_IDLE;
      w_stat_nxt  = ST_OK;
      w_cnt_clr   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_cmd_strobe && (w_stat_base == ST_OK)) begin
            if ((i_cmd_op == DMI_READ) || (i_cmd_op == DMI_WRITE)) begin
              w_state_nxt = S_REQ;
              w_load_cmd  = 1'b1;
              w_cnt_clr   = 1'b1;
            end else if (i_cmd_op == DMI_RSVD) begin
              w_stat_nxt = ST_FAILED;
            end
          end
        end
        S_REQ, S_RSP: begin
          if (i_cmd_strobe) begin
            w_stat_nxt = ST_BUSY;
          end
          // A response arriving on the timeout edge still wins.
          if ((r_state == S_RSP) && i_rsp_valid) begin
            w_state_nxt    = S_IDLE;
            w_done         = 1'b1;
            w_res_data_nxt = (r_req_op == DMI_READ) ? i_rsp_data : '0;
            if (w_stat_nxt == ST_OK) begin
              w_stat_nxt = i_rsp_op;
            end
          end else if (w_expired) begin
            w_state_nxt    = S_IDLE;
            w_done         = 1'b1;
            w_res_data_nxt = '0;
            if (w_stat_nxt == ST_OK) begin
              w_stat_nxt = ST_FAILED;
            end
          end else if ((r_state == S_REQ) && i_req_ready) begin
            w_state_nxt = S_RSP;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stat      <= ST_OK;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_op    <= DMI_NOP;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= ST_OK;
      r_rsp_ready <= 1'b0;
    end else begin
      r_rsp_ready <= 1'b1;
      r_stat      <= w_stat_nxt;
      r_res_valid <= w_done;
      if (w_load_cmd) begin
        r_req_addr <= i_cmd_addr;
        r_req_data <= i_cmd_data;
        r_req_op   <= i_cmd_op;
      end
      if (w_done) begin
        r_res_data <= w_res_data_nxt;
        r_res_op   <= w_stat_nxt;
      end
    end
  end

  assign o_req_valid = (r_state == S_REQ);
  assign o_req_addr  = r_req_addr;
  assign o_req_data  = r_req_data;
  assign o_req_op    = r_req_op;
  assign o_rsp_ready = r_rsp_ready;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_op    = r_res_op;
  assign o_busy      = (r_state != S_IDLE);

endmodule
